// File: rtl/pipe_fetch_unit.sv
// pipe_fetch_unit: IF stage of the 5-stage pipeline.
// Generates the fetch PC, runs a single-outstanding req/ack handshake with a
// variable-latency instruction memory, buffers returned words in a prefetch
// queue and drives the IF/ID register. Applies ID redirects while keeping
// exactly one branch-delay-slot instruction.
// Optional build macro: FETCH_BYPASS_EN (ack goes straight into IF/ID when the
// queue is empty and IF/ID loads).
module pipe_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    input  logic        nostall,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc4
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    // prefetch queue storage
    logic [31:0]   q_inst_q [DEPTH];
    logic [31:0]   q_pc4_q  [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   fpc_q, fpc_d;
    logic          imem_req_q, imem_req_d;
    logic [31:0]   imem_addr_q, imem_addr_d;
    logic          discard_q, discard_d;
    logic          id_valid_q, id_valid_d;
    logic [31:0]   id_inst_q, id_inst_d;
    logic [31:0]   id_pc4_q, id_pc4_d;

    logic          ack_fire;
    logic          redirect;
    logic          flush;
    logic          accept;
    logic          load;
    logic          pop;
    logic          bypass;
    logic          enq;
    logic          hold;
    logic [31:0]   target;
    logic [31:0]   issue_pc;

    // datapath decisions for this edge: handshake, redirect, queue, IF/ID
    always_comb begin
        ack_fire = imem_req_q & imem_ack;
        redirect = id_valid_q & nostall & (pcsource != 2'b00);

        case (pcsource)
            2'b01:   target = bpc;
            2'b10:   target = rpc;
            default: target = jpc;
        endcase
        target = target & ~32'd3;

        // With a queued delay slot everything behind the head is wrong-path;
        // with an empty queue the in-flight word is the delay slot and is kept.
        flush  = redirect & (count_q != '0);
        accept = ack_fire & ~discard_q & ~flush;
        load   = nostall | ~id_valid_q;
        pop    = load & (count_q != '0);
`ifdef FETCH_BYPASS_EN
        bypass = load & (count_q == '0) & accept;
`else
        bypass = 1'b0;
`endif
        enq    = accept & ~bypass;

        // discard bookkeeping for a wrong-path request still in flight
        discard_d = discard_q;
        if (ack_fire && discard_q) begin
            discard_d = 1'b0;
        end
        if (flush && imem_req_q && !imem_ack) begin
            discard_d = 1'b1;
        end

        // queue pointers and occupancy
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (enq) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(enq) - CW'(pop);
        end

        // IF/ID register
        id_valid_d = id_valid_q;
        id_inst_d  = id_inst_q;
        id_pc4_d   = id_pc4_q;
        if (load) begin
            if (count_q != '0) begin
                id_valid_d = 1'b1;
                id_inst_d  = q_inst_q[rd_ptr_q];
                id_pc4_d   = q_pc4_q[rd_ptr_q];
            end else if (bypass) begin
                id_valid_d = 1'b1;
                id_inst_d  = imem_rdata;
                id_pc4_d   = imem_addr_q + 32'd4;
            end else begin
                id_valid_d = 1'b0;
            end
        end

        // request issue: hold until ack, then reissue while a slot remains
        hold        = imem_req_q & ~imem_ack;
        issue_pc    = redirect ? target : fpc_q;
        fpc_d       = issue_pc;
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;
        if (!hold) begin
            imem_req_d = (count_d < CW'(DEPTH));
            if (count_d < CW'(DEPTH)) begin
                imem_addr_d = issue_pc;
                fpc_d       = issue_pc + 32'd4;
            end
        end
    end

    // control and IF/ID state, asynchronously reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            fpc_q       <= RESET_PC;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_PC;
            discard_q   <= 1'b0;
            id_valid_q  <= 1'b0;
            id_inst_q   <= '0;
            id_pc4_q    <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            fpc_q       <= fpc_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            discard_q   <= discard_d;
            id_valid_q  <= id_valid_d;
            id_inst_q   <= id_inst_d;
            id_pc4_q    <= id_pc4_d;
        end
    end

    // queue storage write; contents are qualified by count so need no reset
    always_ff @(posedge clock) begin
        if (enq) begin
            q_inst_q[wr_ptr_q] <= imem_rdata;
            q_pc4_q[wr_ptr_q]  <= imem_addr_q + 32'd4;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign id_valid  = id_valid_q;
    assign id_inst   = id_inst_q;
    assign id_pc4    = id_pc4_q;

endmodule

// File: tb/tb_pipe_fetch_unit.sv
// Bench for pipe_fetch_unit: memory returns rdata = address with a
// programmable ack delay; an instruction-stream model checks every word that
// enters ID, and directed scenarios pin cycle-exact literals.
module tb_pipe_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
    localparam int D    = 2;  // edge after reset at which inst 0 is in ID
    localparam int FILL = 4;  // stalled edges until the queue is full
`else
    localparam int D    = 3;
    localparam int FILL = 3;
`endif

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [1:0]  pcsource;
    logic [31:0] bpc, rpc, jpc;
    logic        nostall;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc4;

    int errors = 0;
    int checks = 0;

    int unsigned lat = 0;
    int unsigned wait_cnt;

    pipe_fetch_unit #(.DEPTH(4), .RESET_PC(RST_PC)) dut (
        .clock      (clock),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .rpc        (rpc),
        .jpc        (jpc),
        .nostall    (nostall),
        .id_valid   (id_valid),
        .id_inst    (id_inst),
        .id_pc4     (id_pc4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // memory: acks after 'lat' waiting cycles, word = its address
    always @(posedge clock or posedge reset) begin
        if (reset)                      wait_cnt <= 0;
        else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
        else                            wait_cnt <= 0;
    end
    assign imem_ack   = imem_req && (wait_cnt >= lat);
    assign imem_rdata = imem_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // instruction-stream model and handshake checks, sampled at negedge
    logic [31:0] exp_q[$];
    logic [31:0] cur_pc;
    logic [31:0] nxt;
    logic [31:0] tgt;
    logic        prev_load;
    logic        prev_req;
    logic        prev_ack;
    logic [31:0] prev_addr;
    int          idle;

    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            cur_pc    = RST_PC - 32'd4;
            prev_load = 1'b1;
            prev_req  = 1'b0;
            prev_ack  = 1'b0;
            prev_addr = '0;
            idle      = 0;
        end else begin
            chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
            if (prev_req && !prev_ack) begin
                chk("req_held", 32'(imem_req), 32'd1);
                chk("addr_stable", imem_addr, prev_addr);
            end
            if (id_valid && prev_load) begin
                nxt = (exp_q.size() > 0) ? exp_q.pop_front() : cur_pc + 32'd4;
                chk("stream_inst", id_inst, nxt);
                chk("stream_pc4", id_pc4, nxt + 32'd4);
                cur_pc = nxt;
                idle   = 0;
            end else if (nostall) begin
                idle++;
                if (idle > 40) begin
                    checks++;
                    errors++;
                    $display("FAIL stream_progress: got no instruction for %0d cycles expected at most 40", idle);
                    idle = 0;
                end
            end
            if (id_valid && nostall && pcsource != 2'b00) begin
                case (pcsource)
                    2'b01:   tgt = bpc;
                    2'b10:   tgt = rpc;
                    default: tgt = jpc;
                endcase
                exp_q.delete();
                exp_q.push_back(cur_pc + 32'd4);
                exp_q.push_back(tgt & ~32'd3);
            end
            prev_load = nostall || !id_valid;
            prev_req  = imem_req;
            prev_ack  = imem_ack;
            prev_addr = imem_addr;
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset(input int unsigned l);
        reset    = 1'b1;
        nostall  = 1'b1;
        pcsource = 2'b00;
        lat      = l;
        tick();
        tick();
        reset = 1'b0;
    endtask

    int  k;
    bit  fired;
    bit  done;
    logic [31:0] x;

    initial begin
        reset    = 1'b1;
        nostall  = 1'b1;
        pcsource = 2'b00;
        bpc      = '0;
        rpc      = '0;
        jpc      = '0;
        tick();
        tick();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_inst", id_inst, 32'd0);
        chk("rst_pc4", id_pc4, 32'd0);
        reset = 1'b0;

        // zero-wait sequential fetch
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (n <= 3) chk("seq_addr", imem_addr, 32'(4 * (n - 1)));
            if (n == 1) chk("first_req", 32'(imem_req), 32'd1);
            if (n == D - 1) chk("ack_latency_not_yet", 32'(id_valid), 32'd0);
            if (n >= D && n <= D + 2) begin
                chk("seq_valid", 32'(id_valid), 32'd1);
                chk("seq_inst", id_inst, 32'(4 * (n - D)));
                chk("seq_pc4", id_pc4, 32'(4 * (n - D) + 4));
            end
        end

        // stall for 8 cycles: queue fills, request drops, IF/ID holds
        x = 32'(4 * (10 - D));
        nostall = 1'b0;
        for (int n = 11; n <= 18; n++) begin
            tick();
            chk("stall_hold_pc4", id_pc4, x + 32'd4);
            chk("stall_req", 32'(imem_req), 32'(n < 10 + FILL));
        end
        nostall = 1'b1;
        tick();
        chk("unstall_req", 32'(imem_req), 32'd1);
        chk("unstall_addr", imem_addr, x + 32'd20);
        repeat (8) tick();

        // branch at 0x10 to 0x100
        do_reset(0);
        for (int n = 1; n <= D + 8; n++) begin
            tick();
            if (n == D + 5) begin
                pcsource = 2'b00;
                chk("br_slot_valid", 32'(id_valid), 32'd1);
                chk("br_slot_pc4", id_pc4, 32'h18);
                chk("br_target_addr", imem_addr, 32'h100);
            end
            if (n == D + 6) chk("br_bubble", 32'(id_valid), 32'(D == 2));
            if (n == D + 4 + D) chk("br_target_inst", id_inst, 32'h100);
            if (n == D + 4) begin
                pcsource = 2'b01;
                bpc      = 32'h100;
            end
        end

        // jr with slow memory: delay slot is the in-flight request
        do_reset(3);
        k = 0;
        fired = 1'b0;
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            tick();
            pcsource = 2'b00;
            if (fired && id_valid) begin
                k++;
                if (k == 1) begin
                    chk("jr_delay_slot", id_inst, 32'hC);
                end else begin
                    chk("jr_target", id_inst, 32'h200);
                    done = 1'b1;
                end
            end
            if (!fired && id_valid && id_pc4 == 32'hC) begin
                pcsource = 2'b10;
                rpc      = 32'h203;
                fired    = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL jr_timeout: got %0d words after redirect expected 2", k);
        end
        repeat (10) tick();

        // jump near the top of the address space, fetch wraps to 0
        do_reset(0);
        for (int n = 1; n <= D + 8; n++) begin
            tick();
            if (n == D + 3) begin
                pcsource = 2'b00;
                chk("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
            end
            if (n == D + 4) chk("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
            if (n == D + 5) chk("wrap_addr2", imem_addr, 32'h0000_0000);
            if (n == D + 3 + D) begin
                chk("wrap_inst", id_inst, 32'hFFFF_FFFC);
                chk("wrap_pc4", id_pc4, 32'h0000_0000);
            end
            if (n == D + 2) begin
                pcsource = 2'b11;
                jpc      = 32'hFFFF_FFF8;
            end
        end
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000");
        $fatal(1);
    end

endmodule

// File: doc/pipe_fetch_unit.md
# pipe_fetch_unit

Instruction-fetch stage of the 5-stage pipelined CPU, sitting directly upstream of the ID-stage control unit. It generates the fetch PC and runs a request/acknowledge handshake with a variable-latency instruction memory. Returned words are buffered in a small prefetch queue, and the IF/ID pipeline register is driven from it. It applies the `pcsource` redirect computed in ID, preserving exactly one branch-delay-slot instruction, and holds on `nostall`.

## Interface
- `DEPTH`, 4: prefetch queue entries; power of two, at least 2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: fetch address; bits [1:0] are always 0.
- `imem_ack` in 1: request accepted and `imem_rdata` valid this cycle.
- `imem_rdata` in 32: instruction word.
- `pcsource` in 2: from ID. 00 = sequential, 01 = branch (`bpc`), 10 = `jr` (`rpc`), 11 = `j`/`jal` (`jpc`).
- `bpc`, `rpc`, `jpc` in 32 each: redirect targets computed in ID.
- `nostall` in 1: from ID; 0 holds IF/ID.
- `id_valid` out 1: IF/ID holds a real instruction.
- `id_inst` out 32: instruction in ID.
- `id_pc4` out 32: PC+4 of the instruction in ID.

## Operation
- State: fetch pointer `fpc`, queue of {inst, pc4} with `count`, in-flight flag, discard flag, IF/ID register.
- Request rule:
  - `imem_req` is registered.
  - Once raised, `imem_req` and `imem_addr` stay stable until the `imem_ack` edge.
  - At most one request is outstanding.
  - After an ack edge, `imem_req` stays 1 with `imem_addr = fpc` (already advanced by 4) if `count_next < DEPTH`. The in-flight request always owns one slot.
- Ack with discard = 0: {`imem_rdata`, `imem_addr + 4`} is enqueued. Ack with discard = 1: data is dropped and the discard flag clears.
- IF/ID load: when `nostall` = 1 or `id_valid` = 0.
  - Queue non-empty: the head is popped into IF/ID and `id_valid` = 1.
  - Queue empty: `id_valid` becomes 0.
  - `nostall` = 0 with `id_valid` = 1: IF/ID and the head are held.
- Redirect condition: `id_valid & nostall & (pcsource != 00)`. The delay slot is the instruction at `id_pc4`.
  - `count >= 1`: the head is kept as the delay slot (it moves to IF/ID this edge), all other entries are flushed, and any in-flight request or same-cycle ack is discarded.
  - `count == 0`: the in-flight request is the delay slot and is kept; a same-cycle ack is enqueued.
  - In both cases `fpc <= target & ~3`. The next new request uses the target.
- A branch inside a delay slot is architecturally unpredictable. The block still follows the redirect rules and must never deadlock.
- PC arithmetic is 32-bit modulo 2^32; 0xFFFF_FFFC + 4 = 0.

## Timing
- Reset values: `imem_req` 0, `imem_addr` = `RESET_PC`, `id_valid` 0, `id_inst` 0, `id_pc4` 0, `count` 0, discard 0, `fpc` = `RESET_PC`.
- Reset mid-request: the request is abandoned. The memory must ignore an ack for an abandoned request.
- `imem_req` rises at the first edge after `reset` deasserts.
- Ack-to-ID latency: ack at edge t writes the queue; `id_valid` = 1 after edge t+1.
- Zero-wait memory: one instruction per cycle, steady state.
- Redirect at edge t: the delay slot is in ID after edge t (if it was queued). `imem_addr` = target from edge t, or from the discard-ack edge if a wrong-path request was in flight.
- Full queue: `imem_req` is 0. It reasserts the cycle after a pop frees a slot.
- Simultaneous pop and enqueue keeps `count` unchanged.

## Configuration
- Macro: `FETCH_BYPASS_EN`.
- Defined: an ack with discard = 0, when the queue is empty and IF/ID loads, goes straight into IF/ID at the ack edge. Ack-to-ID latency becomes 1 edge.
- Undefined: every ack goes through the queue, giving the 2-edge latency above.
- Redirect, discard and reset rules are identical in both builds.

## Test plan
- Reset release, zero-wait memory returning `imem_rdata = addr`: `imem_addr` sequence 0, 4, 8…; `id_inst` 0, 4, 8 on consecutive cycles; `id_pc4` = `id_inst` + 4.
- Memory with 3-cycle ack delay: `imem_req` held with a stable address for 3 cycles; exactly one outstanding request; no duplicated or skipped words.
- `nostall` = 0 for 8 cycles with DEPTH = 4: the queue fills to 4, `imem_req` drops, IF/ID holds. Release resumes in order.
- Branch at 0x10 with `pcsource` = 01 and `bpc` = 0x100, queue non-empty: ID sees 0x14, then 0x100. The wrong-path ack for 0x18 is dropped.
- `jr` with `rpc` = 0x203, queue empty and delay-slot request in flight: the delay slot at `id_pc4` is delivered, then fetch continues at 0x200.
- Wrap-around: start at 0xFFFF_FFF8 gives fetches at 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0. With `FETCH_BYPASS_EN` defined, the ack-to-`id_valid` latency is 1 edge.
